// File: rtl/uart_pkg.sv
// Shared definitions for the UART command sequencer.
//   - Opcode values carried in byte1 of a command packet
//   - Response bytes written back to the TX FIFO
//   - State encodings for the sequencer FSM and the RX byte reader
//   - Small arithmetic helpers shared by both modules
package uart_pkg;

  localparam logic [7:0] OP_START  = 8'h01;
  localparam logic [7:0] OP_CFG    = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  // Packet-level sequencer states. HUNT reads byte0 looking for sync;
  // COLLECT reads bytes 1..3 under the inter-byte timeout.
  typedef enum logic [3:0] {
    HUNT       = 4'd0,
    COLLECT    = 4'd1,
    CHECK      = 4'd2,
    EXEC_START = 4'd3,
    TX_WAIT    = 4'd4,
    TX_PUSH    = 4'd5
  } seq_state_t;

  // Byte-level RX FIFO pop handshake states.
  typedef enum logic [3:0] {
    RD_IDLE = 4'd0,
    RD_REQ  = 4'd1,
    RD_WAIT = 4'd2,
    RD_CAP  = 4'd3
  } rd_state_t;

  // Saturating increment used by the protocol-error counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? 8'hFF : value + 8'd1;
  endfunction

  // A packet is intact when all four bytes XOR to zero.
  function automatic logic packet_ok(input logic [7:0] b0,
                                     input logic [7:0] b1,
                                     input logic [7:0] b2,
                                     input logic [7:0] b3);
    return (b0 ^ b1 ^ b2 ^ b3) == 8'h00;
  endfunction

endpackage

// File: rtl/uart_fifo_byte_reader.sv
// RX FIFO byte reader for the UART command sequencer.
// Pops one byte at a time from the RX FIFO with a three-state handshake
// and watches the gap between bytes of a packet.
// Ports:
//   clk, rst              - system clock, async active-high reset
//   read_req              - sequencer wants another byte
//   timeout_en            - sequencer is mid-packet; gaps are timed
//   rx_fifo_data          - FIFO read data, valid the cycle after the pop
//   rx_fifo_empty         - FIFO empty flag
//   rx_fifo_read_enable   - one-cycle pop strobe
//   byte_valid            - byte_data is a freshly popped byte this cycle
//   byte_data             - popped byte, to be latched by the consumer
//   timeout               - one-cycle flag: too long waiting on an empty FIFO
module uart_fifo_byte_reader
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       read_req,
  input  logic       timeout_en,
  input  logic [7:0] rx_fifo_data,
  input  logic       rx_fifo_empty,
  output logic       rx_fifo_read_enable,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       timeout
);

  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

  rd_state_t   state;
  rd_state_t   next_state;
  logic [19:0] timer;
  logic        waiting;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RD_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A pop is only launched from idle with data present, and every pop
  // walks REQ -> WAIT -> CAP -> IDLE, so pops are at least four cycles
  // apart and never hit an empty FIFO.
  always_comb begin
    next_state          = state;
    rx_fifo_read_enable = 1'b0;
    byte_valid          = 1'b0;
    case (state)
      RD_IDLE: begin
        if (read_req && !rx_fifo_empty) begin
          next_state = RD_REQ;
        end
      end
      RD_REQ: begin
        rx_fifo_read_enable = 1'b1;
        next_state          = RD_WAIT;
      end
      RD_WAIT: begin
        next_state = RD_CAP;
      end
      RD_CAP: begin
        byte_valid = 1'b1;
        next_state = RD_IDLE;
      end
      default: begin
        next_state = RD_IDLE;
      end
    endcase
  end

  // The FIFO holds its read data after the pop, so the consumer latches
  // it directly on the capture edge.
  assign byte_data = rx_fifo_data;

  // Only cycles spent idle on an empty FIFO while mid-packet count.
  assign waiting = (state == RD_IDLE) && read_req && timeout_en && rx_fifo_empty;
  assign timeout = waiting && (timer == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= 20'd0;
    end else if (!timeout_en || (state == RD_CAP) || timeout) begin
      timer <= 20'd0;
    end else if (waiting) begin
      timer <= timer + 20'd1;
    end
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Packet-level command controller between the UART RX/TX FIFOs and the
// frame-write datapath. Hunts for 4-byte packets {sync, opcode, arg, chk},
// validates them and dispatches a frame-start pulse, a config write or a
// status query, answering each accepted packet with ACK/NAK (plus a
// status byte for queries) on the TX FIFO.
// Ports:
//   clk, rst               - system clock, async active-high reset
//   rx_fifo_data           - RX FIFO read data (valid the cycle after a pop)
//   rx_fifo_read_enable    - one-cycle RX pop strobe
//   rx_fifo_empty          - RX FIFO empty flag
//   tx_fifo_data           - response byte toward the TX FIFO
//   tx_fifo_write_enable   - one-cycle TX push strobe
//   tx_fifo_full           - TX FIFO full flag
//   frame_busy             - frame writer busy
//   start_write_frame      - frame-write start pulse
//   cfg_reg                - configuration register (opcode 0x02)
//   err_count              - saturating protocol-error counter
module uart_cmd_sequencer
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE          = 8'hA5,
  parameter int         START_PULSE_CYCLES = 32,
  parameter int         TIMEOUT_CYCLES     = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_fifo_data,
  output logic       rx_fifo_read_enable,
  input  logic       rx_fifo_empty,
  output logic [7:0] tx_fifo_data,
  output logic       tx_fifo_write_enable,
  input  logic       tx_fifo_full,
  input  logic       frame_busy,
  output logic       start_write_frame,
  output logic [7:0] cfg_reg,
  output logic [7:0] err_count
);

  localparam logic [7:0] PULSE_LAST = 8'(START_PULSE_CYCLES - 1);

  seq_state_t state;
  seq_state_t next_state;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       timeout;
  logic       read_req;
  logic       timeout_en;

  logic [1:0] byte_idx;
  logic [7:0] opcode;
  logic [7:0] arg;
  logic [7:0] chk;

  logic [7:0] resp0;
  logic [7:0] resp1;
  logic       resp_two;
  logic       tx_sel;
  logic [7:0] tx_hold;
  logic [7:0] cur_byte;
  logic [7:0] pulse_cnt;

  logic       sync_seen;
  logic       sum_ok;
  logic       start_go;
  logic       cfg_wr;
  logic       err_bump;
  logic [7:0] resp0_d;
  logic       resp_two_d;
  logic [7:0] status_byte;

  // Reads are only requested from the two hunting/collecting states, so
  // bytes arriving during execution or response stay in the RX FIFO.
  assign read_req   = (state == HUNT) || (state == COLLECT);
  assign timeout_en = (state == COLLECT);

  uart_fifo_byte_reader #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_reader (
    .clk                (clk),
    .rst                (rst),
    .read_req           (read_req),
    .timeout_en         (timeout_en),
    .rx_fifo_data       (rx_fifo_data),
    .rx_fifo_empty      (rx_fifo_empty),
    .rx_fifo_read_enable(rx_fifo_read_enable),
    .byte_valid         (byte_valid),
    .byte_data          (byte_data),
    .timeout            (timeout)
  );

  assign sync_seen = byte_valid && (byte_data == SYNC_BYTE);
  assign sum_ok    = packet_ok(SYNC_BYTE, opcode, arg, chk);

  // The status byte snapshots the TX full flag as seen in the CHECK cycle.
  assign status_byte = {frame_busy, tx_fifo_full, cfg_reg[5:0]};

  // Packet decode, meaningful only in the CHECK cycle. A busy frame writer
  // is a refusal, not a protocol error, so it does not bump err_count.
  always_comb begin
    resp0_d    = NAK;
    resp_two_d = 1'b0;
    start_go   = 1'b0;
    cfg_wr     = 1'b0;
    err_bump   = 1'b0;
    if (!sum_ok) begin
      err_bump = 1'b1;
    end else begin
      case (opcode)
        OP_START: begin
          if (!frame_busy) begin
            resp0_d  = ACK;
            start_go = 1'b1;
          end
        end
        OP_CFG: begin
          resp0_d = ACK;
          cfg_wr  = 1'b1;
        end
        OP_STATUS: begin
          resp0_d    = ACK;
          resp_two_d = 1'b1;
        end
        default: begin
          err_bump = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= next_state;
    end
  end

  // TX_WAIT pushes on the first not-full cycle; TX_PUSH decides whether a
  // second (status) byte follows or the packet is finished.
  always_comb begin
    next_state = state;
    case (state)
      HUNT: begin
        if (sync_seen) begin
          next_state = COLLECT;
        end
      end
      COLLECT: begin
        if (timeout) begin
          next_state = HUNT;
        end else if (byte_valid && (byte_idx == 2'd3)) begin
          next_state = CHECK;
        end
      end
      CHECK: begin
        next_state = start_go ? EXEC_START : TX_WAIT;
      end
      EXEC_START: begin
        if (pulse_cnt == PULSE_LAST) begin
          next_state = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (!tx_fifo_full) begin
          next_state = TX_PUSH;
        end
      end
      TX_PUSH: begin
        next_state = (resp_two && !tx_sel) ? TX_WAIT : HUNT;
      end
      default: begin
        next_state = HUNT;
      end
    endcase
  end

  // Packet bytes, config/error registers and response bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx  <= 2'd0;
      opcode    <= 8'h00;
      arg       <= 8'h00;
      chk       <= 8'h00;
      cfg_reg   <= 8'h00;
      err_count <= 8'h00;
      resp0     <= 8'h00;
      resp1     <= 8'h00;
      resp_two  <= 1'b0;
      tx_sel    <= 1'b0;
      tx_hold   <= 8'h00;
      pulse_cnt <= 8'h00;
    end else begin
      case (state)
        HUNT: begin
          if (sync_seen) begin
            byte_idx <= 2'd1;
          end
        end
        COLLECT: begin
          if (timeout) begin
            err_count <= sat_inc(err_count);
            byte_idx  <= 2'd0;
          end else if (byte_valid) begin
            case (byte_idx)
              2'd1:    opcode <= byte_data;
              2'd2:    arg    <= byte_data;
              default: chk    <= byte_data;
            endcase
            byte_idx <= byte_idx + 2'd1;
          end
        end
        CHECK: begin
          resp0     <= resp0_d;
          resp1     <= status_byte;
          resp_two  <= resp_two_d;
          tx_sel    <= 1'b0;
          pulse_cnt <= 8'h00;
          if (cfg_wr) begin
            cfg_reg <= arg;
          end
          if (err_bump) begin
            err_count <= sat_inc(err_count);
          end
        end
        EXEC_START: begin
          pulse_cnt <= pulse_cnt + 8'd1;
        end
        TX_WAIT: begin
          if (!tx_fifo_full) begin
            tx_hold <= cur_byte;
          end
        end
        TX_PUSH: begin
          if (resp_two && !tx_sel) begin
            tx_sel <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The data bus shows the outgoing byte only while pushing and otherwise
  // holds the last byte written, so it never wanders between pushes.
  assign cur_byte             = tx_sel ? resp1 : resp0;
  assign tx_fifo_write_enable = (state == TX_WAIT) && !tx_fifo_full;
  assign tx_fifo_data         = tx_fifo_write_enable ? cur_byte : tx_hold;

  // Decoded from the state register so an async reset cuts the pulse off.
  assign start_write_frame = (state == EXEC_START);

endmodule
